// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF/ID pipeline queue.
package if_id_queue_pkg;

   // Field widths of a queued entry. They bound the DATA_WIDTH / PC_SIZE
   // parameters of if_id_queue.
   localparam int ENTRY_INST_W = 32;
   localparam int ENTRY_PC_W   = 32;

   // addi x0,x0,0 -- presented to decode whenever the queue is empty.
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [ENTRY_INST_W-1:0] inst;
      logic [ENTRY_PC_W-1:0]   pc;
      logic [ENTRY_PC_W-1:0]   pc4;
   } if_id_entry_t;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small circular FIFO between fetch and decode.
// Handshake outputs depend on registered occupancy only; the head entry is
// read combinationally from storage, and an empty queue presents a NOP.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DATA_WIDTH = ENTRY_INST_W,
   parameter int PC_SIZE    = ENTRY_PC_W,
   parameter int DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_inst,
   input  logic [PC_SIZE-1:0]           in_pc,
   input  logic [PC_SIZE-1:0]           in_pc4,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_inst,
   output logic [PC_SIZE-1:0]           out_pc,
   output logic [PC_SIZE-1:0]           out_pc4,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push;
   logic             pop;
   if_id_entry_t     in_entry;
   if_id_entry_t     head;
   if_id_entry_t     mem [DEPTH];

   // Handshakes come from occupancy alone, so in_ready never waits on decode.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign head      = mem[rd_ptr];

   // Pack the fetch-side fields into a storage entry.
   always_comb begin
      in_entry.inst = ENTRY_INST_W'(in_inst);
      in_entry.pc   = ENTRY_PC_W'(in_pc);
      in_entry.pc4  = ENTRY_PC_W'(in_pc4);
   end

   // Present the head entry, or a NOP with zero PCs when empty.
   always_comb begin
      // NOTE: every output gets a default before the condition, so no path leaves it unassigned and no latch is inferred.
      out_inst = DATA_WIDTH'(NOP_INST);
      out_pc   = '0;
      out_pc4  = '0;
      if (out_valid) begin
         out_inst = DATA_WIDTH'(head.inst);
         out_pc   = PC_SIZE'(head.pc);
         out_pc4  = PC_SIZE'(head.pc4);
      end
   end

   // Storage write at the write pointer; contents survive flush and reset.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; occupancy alone decides what is visible, which keeps it plain RAM.
      if (arst_n && push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Pointers and occupancy: reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values of its neighbours.
      if (!arst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits, so the increment wraps by itself.
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a long random
// run, all compared against a queue-based reference model.
module tb_if_id_queue;

   localparam int DW    = 32;
   localparam int PW    = 32;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk;
   logic          arst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_inst;
   logic [PW-1:0] in_pc;
   logic [PW-1:0] in_pc4;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_inst;
   logic [PW-1:0] out_pc;
   logic [PW-1:0] out_pc4;
   logic [CW-1:0] count;

   if_id_queue #(.DATA_WIDTH(DW), .PC_SIZE(PW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_pc4    (in_pc4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_pc4   (out_pc4),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc4;
   } m_entry_t;

   m_entry_t model_q[$];
   int       n_checks = 0;
   int       n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: FIFO of entries; accept rules come from the occupancy
   // seen before the edge.
   task automatic model_step(input logic r, input logic f, input logic v,
                             input logic [31:0] inst, input logic [31:0] pc,
                             input logic o);
      int  sz;
      bit  do_push;
      bit  do_pop;
      m_entry_t e;
      sz = model_q.size();
      if (!r || f) begin
         model_q.delete();
      end else begin
         do_push = v && (sz != DEPTH);
         do_pop  = o && (sz != 0);
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            e.inst = inst;
            e.pc   = pc;
            e.pc4  = pc + 32'd4;
            model_q.push_back(e);
         end
      end
   endtask

   task automatic compare_model();
      int sz;
      sz = model_q.size();
      check("count",     32'(count),     32'(sz));
      check("count_max", 32'(count <= CW'(DEPTH)), 32'd1);
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      check("in_ready",  32'(in_ready),  32'(sz != DEPTH));
      if (sz != 0) begin
         check("out_inst", out_inst, model_q[0].inst);
         check("out_pc",   out_pc,   model_q[0].pc);
         check("out_pc4",  out_pc4,  model_q[0].pc4);
      end else begin
         check("out_inst_nop", out_inst, 32'h0000_0013);
         check("out_pc_nop",   out_pc,   32'h0);
         check("out_pc4_nop",  out_pc4,  32'h0);
      end
   endtask

   // Drive one cycle's inputs, advance the model, then sample on the falling edge.
   task automatic cycle(input logic r, input logic f, input logic v,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic o);
      arst_n    = r;
      flush     = f;
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      in_pc4    = pc + 32'd4;
      out_ready = o;
      model_step(r, f, v, inst, pc, o);
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      logic [31:0] fetch_pc;
      logic [31:0] exp_pc;
      bit          accepted;

      arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0; in_pc4 = '0;

      // Reset state, with stimulus on the inputs that must be ignored.
      cycle(1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h100, 1'b1);
      check("rst_count",    32'(count),     32'd0);
      check("rst_out_valid",32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready),  32'd1);
      check("rst_out_inst", out_inst,       32'h0000_0013);
      check("rst_out_pc",   out_pc,         32'h0);

      // First word available one cycle after the push.
      cycle(1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h0, 1'b0);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_inst",  out_inst,       32'h0050_0093);
      check("first_pc4",   out_pc4,        32'h4);
      check("first_count", 32'(count),     32'd1);

      // Fill past capacity: the third push is dropped.
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA000_0000, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA000_0004, 32'h4, 1'b0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA000_0008, 32'h8, 1'b0);
      check("full_count",    32'(count), 32'd2);
      check("full_head_pc",  out_pc,     32'h0);

      // Full queue streaming with push and pop held high; fetch holds its PC
      // whenever the queue refuses the entry.
      fetch_pc = 32'h8;
      exp_pc   = 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (model_q.size() != 0) begin
            check("stream_pc", out_pc, exp_pc);
            exp_pc += 32'd4;
         end
         accepted = (model_q.size() != DEPTH);
         cycle(1'b1, 1'b0, 1'b1, 32'hA000_0000 | fetch_pc, fetch_pc, 1'b1);
         if (accepted) fetch_pc += 32'd4;
      end

      // Flush drops both queued entries and the same-cycle push.
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hB000_0000, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hB000_0004, 32'h4, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'hB000_0040, 32'h40, 1'b0);
      check("flush_count",    32'(count),     32'd0);
      check("flush_valid",    32'(out_valid), 32'd0);
      check("flush_inst_nop", out_inst,       32'h0000_0013);
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check("flush_empty_count", 32'(count), 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 32'hB000_0080, 32'h80, 1'b0);
      check("after_flush_pc", out_pc, 32'h80);

      // Push and pop together on an empty queue: only the push happens.
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hC000_0000, 32'h200, 1'b1);
      check("empty_pushpop_count", 32'(count), 32'd1);

      // Reset mid-operation with a push pending.
      cycle(1'b0, 1'b0, 1'b1, 32'hD000_0000, 32'h300, 1'b0);
      check("midrst_count",    32'(count),     32'd0);
      check("midrst_valid",    32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready),  32'd1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check("midrst_stay_empty", 32'(out_valid), 32'd0);

      // Random traffic against the model, including occasional flush/reset.
      fetch_pc = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         logic r, f, v, o;
         r = ($urandom_range(255) != 0);
         f = ($urandom_range(63) == 0);
         v = $urandom_range(1);
         o = $urandom_range(1);
         accepted = r && !f && v && (model_q.size() != DEPTH);
         cycle(r, f, v, $urandom, fetch_pc, o);
         if (accepted) fetch_pc += 32'd4;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter PC_SIZE, default 32, program-counter width in bits.
REQ-003 Parameter DEPTH, default 2, number of entries; SHALL be a power of two, 2 or greater.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 arst_n  input  1  reset, synchronous and active-low.
REQ-006 flush  input  1  discard all queued entries; driven by branch-taken from execute.
REQ-007 in_valid  input  1  fetch side presents an entry.
REQ-008 in_ready  output  1  queue accepts an entry this cycle.
REQ-009 in_inst / in_pc / in_pc4  input  DATA_WIDTH / PC_SIZE / PC_SIZE  fetched instruction, its PC, and PC+4.
REQ-010 out_valid  output  1  head entry is available to decode.
REQ-011 out_ready  input  1  decode consumes the head entry this cycle.
REQ-012 out_inst / out_pc / out_pc4  output  DATA_WIDTH / PC_SIZE / PC_SIZE  head entry fields.
REQ-013 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-014 Push occurs when in_valid && in_ready && !flush; the entry is written at the write pointer.
REQ-015 Pop occurs when out_valid && out_ready && !flush; the read pointer advances by one.
REQ-016 in_ready = (count != DEPTH); it SHALL depend only on registered state, never on out_ready.
REQ-017 out_valid = (count != 0); it SHALL be registered-state only.
REQ-018 out_* SHALL present the head entry combinationally from storage; first-word latency is 1 cycle after push.
REQ-019 When out_valid=0: out_inst = 32'h0000_0013 (NOP, addi x0,x0,0), and out_pc = out_pc4 = 0.
REQ-020 Pointers are log2(DEPTH) bits and wrap modulo DEPTH without a special case.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
REQ-022 Simultaneous push and pop when count=0: the push is accepted and the pop does not occur (out_valid=0); count becomes 1.
REQ-023 When count=DEPTH with pop asserted: the pop is accepted, the push is rejected (in_ready=0), and count becomes DEPTH-1.
REQ-024 Flush has priority over push and pop: next cycle count=0, pointers=0, and the same-cycle input is dropped.
REQ-025 Flush with an empty queue is legal; the state stays empty.
REQ-026 Storage contents are not cleared by flush; only occupancy is cleared.
REQ-027 count increments and decrements by at most 1 per cycle and SHALL never exceed DEPTH or underflow.

Reset
REQ-028 With arst_n=0 at a rising edge: count=0, read and write pointers=0, out_valid=0, in_ready=1, out_inst=NOP, out_pc=out_pc4=0.
REQ-029 Reset has priority over flush, push and pop.
REQ-030 Reset mid-operation SHALL discard all entries; no entry is presented after reset deasserts until a new push.
REQ-031 The storage array has no reset.

Structure
REQ-032 Package if_id_queue_pkg SHALL hold the typedef if_id_entry_t {inst, pc, pc4} and the constant NOP_INST = 32'h0000_0013.
REQ-033 Storage SHALL be an array of if_id_entry_t.
REQ-034 No sub-module is required; pointer and count logic SHALL be inline.
REQ-035 in_* SHALL connect directly to the fetch stage outputs (inst, pc, pc4); the fetch stage PC-hold on !in_ready is outside this block.

Verification
REQ-036 Reset, then in_valid=1 with in_inst=0x00500093, in_pc=0x0, out_ready=0 -> next cycle out_valid=1, out_inst=0x00500093, out_pc4=0x4, count=1.
REQ-037 DEPTH=2, out_ready=0, three pushes with pc=0x0/0x4/0x8 -> in_ready=0 after the second push, third entry dropped, count=2, head pc=0x0.
REQ-038 Full queue, in_valid=1 and out_ready=1 held for 4 cycles with pcs 0x8, 0xC, ... -> out_pc sequence 0x0, 0x4, 0x8, 0xC, ... with no loss or duplication; pointer wrap exercised.
REQ-039 count=2, flush=1 with in_valid=1 (pc=0x40) -> next cycle count=0, out_valid=0, out_inst=0x00000013; the 0x40 entry is absent.
REQ-040 count=1, arst_n=0 for one cycle with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-041 Random in_valid/out_ready over 10k cycles against a reference queue model -> identical pop order and count≤DEPTH every cycle.
